// File: rtl/curve_point_deserializer.sv
// Assembles LS-word-first stream words into one packed {x, y} curve point.
// Optional macro POINT_RANGE_CHECK_EN adds an advisory x/y >= MODULUS flag.
module curve_point_deserializer #(
    parameter int P_WIDTH = 256,
    parameter int WORD_W  = 32,
    parameter logic [P_WIDTH-1:0] MODULUS =
        256'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [2*P_WIDTH-1:0] out_point,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_is_inf,
    output logic                 out_range_err,
    output logic                 frame_err
);

    localparam int N     = (P_WIDTH + WORD_W - 1) / WORD_W;
    localparam int FRAME = 2 * N;
    localparam int BUF_W = N * WORD_W;
    localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic [CNT_W-1:0] X_WORDS  = CNT_W'(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0]     r_cnt;
    logic [BUF_W-1:0]     r_x;
    logic [BUF_W-1:0]     r_y;
    logic [2*P_WIDTH-1:0] r_point;
    logic                 r_inf;
    logic                 r_rerr;
    logic                 r_ferr;

    logic                 w_accept;
    logic                 w_is_x;
    logic                 w_at_end;
    logic                 w_done;
    logic [BUF_W-1:0]     w_x_shift;
    logic [BUF_W-1:0]     w_y_shift;
    logic [P_WIDTH-1:0]   w_x_fin;
    logic [P_WIDTH-1:0]   w_y_fin;
    logic                 w_range;

    assign in_ready  = (r_state == COLLECT);
    assign w_accept  = in_valid && in_ready;
    assign w_is_x    = (r_cnt < X_WORDS);
    assign w_at_end  = (r_cnt == LAST_IDX);
    assign w_done    = w_accept && w_at_end && in_last;

    // New words enter at the top so word 0 ends up least significant.
    assign w_x_shift = BUF_W'({in_data, r_x} >> WORD_W);
    assign w_y_shift = BUF_W'({in_data, r_y} >> WORD_W);

    // x is complete before the last word; y includes the word arriving now.
    assign w_x_fin   = r_x[P_WIDTH-1:0];
    assign w_y_fin   = w_y_shift[P_WIDTH-1:0];

`ifdef POINT_RANGE_CHECK_EN
    assign w_range   = (w_x_fin >= MODULUS) || (w_y_fin >= MODULUS);
`else
    assign w_range   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: HOLD owns the single output buffer until it is consumed.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            COLLECT: if (w_done)    w_state_next = HOLD;
            HOLD:    if (out_ready) w_state_next = COLLECT;
            default:                w_state_next = COLLECT;
        endcase
    end

    // Word capture, framing checks and output point registration.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_point <= '0;
            r_inf   <= 1'b0;
            r_rerr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            if (w_accept) begin
                if (w_is_x) begin
                    r_x <= w_x_shift;
                end else begin
                    r_y <= w_y_shift;
                end
                if (w_at_end || in_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_at_end && in_last) begin
                    r_point <= {w_x_fin, w_y_fin};
                    r_inf   <= (w_x_fin == '0) && (w_y_fin == '0);
                    r_rerr  <= w_range;
                end else if (w_at_end || in_last) begin
                    r_ferr  <= 1'b1;
                end
            end
        end
    end

    assign out_valid     = (r_state == HOLD);
    assign out_point     = r_point;
    assign out_is_inf    = r_inf;
    assign out_range_err = r_rerr;
    assign frame_err     = r_ferr;

endmodule

// File: tb/tb_curve_point_deserializer.sv
// Randomized and directed bench for curve_point_deserializer.
// Frame-level queue model compared against the DUT every cycle.
module tb_curve_point_deserializer;

    localparam logic [255:0] MOD =
        256'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f;
    localparam logic [255:0] GX =
        256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY =
        256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [511:0] out_point;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_is_inf;
    logic         out_range_err;
    logic         frame_err;

    int n_chk = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;
    bit rnd_mode = 1'b0;

    logic [31:0]  q[$];
    logic         m_valid = 1'b0;
    logic [511:0] m_point = '0;
    logic         m_inf = 1'b0;
    logic         m_rerr = 1'b0;
    logic         m_ferr = 1'b0;

    curve_point_deserializer dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_point     (out_point),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_is_inf    (out_is_inf),
        .out_range_err (out_range_err),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit exp_rerr(input logic [255:0] x, input logic [255:0] y);
`ifdef POINT_RANGE_CHECK_EN
        return (x >= MOD) || (y >= MOD);
`else
        return 1'b0;
`endif
    endfunction

    // Frame-level model: collect accepted words, judge the frame when it ends.
    always @(posedge clk) begin
        logic [255:0] x;
        logic [255:0] y;
        if (reset) begin
            q.delete();
            m_valid = 1'b0;
            m_point = '0;
            m_inf   = 1'b0;
            m_rerr  = 1'b0;
            m_ferr  = 1'b0;
        end else begin
            m_ferr = 1'b0;
            if (m_valid) begin
                if (out_ready) m_valid = 1'b0;
            end else if (in_valid) begin
                q.push_back(in_data);
                if (in_last || q.size() == 16) begin
                    if (in_last && q.size() == 16) begin
                        x = '0;
                        y = '0;
                        for (int i = 0; i < 8; i++) begin
                            x = x | (256'(q[i]) << (32 * i));
                            y = y | (256'(q[8+i]) << (32 * i));
                        end
                        m_point = {x, y};
                        m_inf   = (x == 0) && (y == 0);
                        m_rerr  = exp_rerr(x, y);
                        m_valid = 1'b1;
                    end else begin
                        m_ferr = 1'b1;
                    end
                    q.delete();
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", 512'(in_ready), 512'(!m_valid));
            chk("out_valid", 512'(out_valid), 512'(m_valid));
            chk("out_point", out_point, m_point);
            chk("out_is_inf", 512'(out_is_inf), 512'(m_inf));
            chk("out_range_err", 512'(out_range_err), 512'(m_rerr));
            chk("frame_err", 512'(frame_err), 512'(m_ferr));
        end
    end

    task automatic put(input logic [31:0] d, input logic l);
        int guard = 0;
        if ($urandom_range(0, 3) == 0) begin
            in_data = $urandom();
            @(posedge clk); #1;
        end
        while (!in_ready && guard < 50) begin
            if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
            in_data = $urandom();
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            chk("in_ready_timeout", 512'(in_ready), 512'(1));
        end
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom();
    endtask

    task automatic frame(input logic [255:0] x, input logic [255:0] y,
                         input int len, input int last_at);
        logic [31:0] w;
        for (int i = 0; i < len; i++) begin
            w = (i < 8) ? x[32*i +: 32] : y[32*(i-8) +: 32];
            put(w, i == last_at);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    initial begin
        logic [255:0] rx;
        logic [255:0] ry;
        int len;
        int la;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_point", out_point, 512'(0));
        chk("rst_out_is_inf", 512'(out_is_inf), 512'(0));
        chk("rst_range_err", 512'(out_range_err), 512'(0));
        chk("rst_frame_err", 512'(frame_err), 512'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        cmp_en = 1'b1;

        frame(GX, GY, 16, 15);
        chk("nom_latency_valid", 512'(out_valid), 512'(1));
        chk("nom_point", out_point, {GX, GY});
        chk("nom_inf", 512'(out_is_inf), 512'(0));
        chk("nom_ferr", 512'(frame_err), 512'(0));

        wait_ready();
        out_ready = 1'b0;
        frame(256'h5, 256'h6, 16, 15);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_last  = 1'($urandom_range(0, 1));
            in_data  = $urandom();
            chk("bp_in_ready", 512'(in_ready), 512'(0));
            chk("bp_point", out_point, {256'h5, 256'h6});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", 512'(in_ready), 512'(1));
        frame(256'h1, 256'h2, 16, 15);
        chk("bp_next_point", out_point, {256'h1, 256'h2});

        wait_ready();
        frame('0, '0, 16, 15);
        chk("inf_flag", 512'(out_is_inf), 512'(1));
        chk("inf_point", out_point, 512'(0));

        wait_ready();
        frame(256'h77, 256'h88, 6, 5);
        chk("early_ferr", 512'(frame_err), 512'(1));
        chk("early_no_valid", 512'(out_valid), 512'(0));
        @(posedge clk); #1;
        chk("early_ferr_pulse", 512'(frame_err), 512'(0));
        frame(256'h3, 256'h4, 16, 15);
        chk("early_next_point", out_point, {256'h3, 256'h4});

        wait_ready();
        frame(256'h9, 256'hA, 16, -1);
        chk("miss_ferr", 512'(frame_err), 512'(1));
        chk("miss_no_valid", 512'(out_valid), 512'(0));
        frame(256'hB, 256'hC, 8, -1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_in_ready", 512'(in_ready), 512'(1));
        chk("midrst_out_valid", 512'(out_valid), 512'(0));
        frame(256'hD, 256'hE, 8, 7);
        chk("midrst_restart_ferr", 512'(frame_err), 512'(1));
        frame(256'hD, 256'hE, 16, 15);
        chk("midrst_point", out_point, {256'hD, 256'hE});

        wait_ready();
        frame(MOD, 256'h1, 16, 15);
`ifdef POINT_RANGE_CHECK_EN
        chk("range_mod", 512'(out_range_err), 512'(1));
`else
        chk("range_mod", 512'(out_range_err), 512'(0));
`endif
        chk("range_mod_point", out_point, {MOD, 256'h1});
        wait_ready();
        frame(MOD - 256'h1, 256'h1, 16, 15);
        chk("range_mod_m1", 512'(out_range_err), 512'(0));

        rnd_mode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            wait_ready();
            for (int k = 0; k < 8; k++) begin
                rx[32*k +: 32] = $urandom();
                ry[32*k +: 32] = $urandom();
            end
            if ($urandom_range(0, 9) == 0) rx = MOD + 256'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                rx = '0;
                ry = '0;
            end
            len = 16;
            la  = 15;
            case ($urandom_range(0, 7))
                0: begin
                    la  = $urandom_range(0, 14);
                    len = la + 1;
                end
                1: la = -1;
                default: ;
            endcase
            frame(rx, ry, len, la);
        end
        rnd_mode = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
